// File: rtl/fifo8_32.sv
`default_nettype none
// ============================================================================
//  Module     : fifo8_32
//  Description: Byte-in / word-out receive FIFO, little-endian packing,
//               show-ahead read port. Define FIFO8_32_LEVEL_EN to add level_o.
//  Revision   : 1.0  initial release
// ============================================================================
module fifo8_32 #(
    parameter int AW = 2
) (
    input  logic          sclk,
    input  logic          rstn,
    input  logic [7:0]    wdata_i,
    input  logic          wr_i,
    output logic [31:0]   rdata_o,
    input  logic          rd_i,
    output logic          empty_o,
`ifdef FIFO8_32_LEVEL_EN
    output logic          full_o,
    output logic [AW+2:0] level_o
`else
    output logic          full_o
`endif
);

    localparam int c_DEPTH = 2 ** AW;
    localparam logic [AW+2:0] c_BYTES = (AW + 3)'(4 * c_DEPTH);

    logic [AW+2:0]  r_wcnt;
    logic [AW+2:0]  r_rcnt;
    logic [31:0]    r_mem [c_DEPTH];

    logic [AW+2:0]  w_level;
    logic           w_wr_en;
    logic           w_rd_en;
    logic [AW-1:0]  w_waddr;
    logic [1:0]     w_lane;
    logic [AW-1:0]  w_raddr;

    // Pointer difference is exact modulo 2^(AW+3) thanks to the wrap bit.
    assign w_level = r_wcnt - r_rcnt;
    assign empty_o = (w_level < (AW + 3)'(4));
    assign full_o  = (w_level == c_BYTES);

    assign w_wr_en = wr_i && !full_o;
    assign w_rd_en = rd_i && !empty_o;

    assign w_waddr = r_wcnt[AW+1:2];
    assign w_lane  = r_wcnt[1:0];
    assign w_raddr = r_rcnt[AW+1:2];

    assign rdata_o = r_mem[w_raddr];

`ifdef FIFO8_32_LEVEL_EN
    assign level_o = w_level;
`endif

    always_ff @(posedge sclk) begin
        if (!rstn) begin
            r_wcnt <= '0;
            r_rcnt <= '0;
            // Storage is cleared so rdata_o is deterministic while empty.
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr_en) begin
                r_mem[w_waddr][{w_lane, 3'b000} +: 8] <= wdata_i;
                r_wcnt <= r_wcnt + (AW + 3)'(1);
            end
            if (w_rd_en) begin
                r_rcnt <= r_rcnt + (AW + 3)'(4);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo8_32.sv
`default_nettype none
// ============================================================================
//  Module     : tb_fifo8_32
//  Description: Scoreboard bench for fifo8_32 (byte packing, full/empty,
//               simultaneous access, pointer wrap, mid-word reset).
//  Revision   : 1.0  initial release
// ============================================================================
module tb_fifo8_32;

    logic        sclk;
    logic        rstn;
    logic [7:0]  wdata_i;
    logic        wr_i;
    logic [31:0] rdata_o;
    logic        rd_i;
    logic        empty_o;
    logic        full_o;
`ifdef FIFO8_32_LEVEL_EN
    logic [4:0]  level_o;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: byte count, word being assembled, completed words.
    int          m_level;
    int          m_lane;
    logic [31:0] m_part;
    logic [31:0] exp_q[$];

    fifo8_32 #(.AW(2)) u_dut (
        .sclk    (sclk),
        .rstn    (rstn),
        .wdata_i (wdata_i),
        .wr_i    (wr_i),
        .rdata_o (rdata_o),
        .rd_i    (rd_i),
        .empty_o (empty_o),
`ifdef FIFO8_32_LEVEL_EN
        .full_o  (full_o),
        .level_o (level_o)
`else
        .full_o  (full_o)
`endif
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Checks flags against the model, then applies one clock of stimulus.
    task automatic cycle(input logic wr, input logic [7:0] d, input logic rd);
        logic pre_empty;
        logic pre_full;
        pre_empty = (m_level < 4);
        pre_full  = (m_level == 16);
        check("empty", {31'd0, empty_o}, {31'd0, pre_empty});
        check("full",  {31'd0, full_o},  {31'd0, pre_full});
`ifdef FIFO8_32_LEVEL_EN
        check("level", {27'd0, level_o}, 32'(m_level));
`endif
        if (rd && !pre_empty) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_underflow", 32'd1, 32'd0);
            end else begin
                check("rdata", rdata_o, exp_q.pop_front());
            end
            m_level -= 4;
        end
        if (wr && !pre_full) begin
            m_part[m_lane*8 +: 8] = d;
            m_lane++;
            m_level++;
            if (m_lane == 4) begin
                exp_q.push_back(m_part);
                m_lane = 0;
                m_part = '0;
            end
        end
        wr_i    = wr;
        wdata_i = d;
        rd_i    = rd;
        @(posedge sclk);
        #1;
        wr_i = 1'b0;
        rd_i = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        wr_i = 1'b0;
        rd_i = 1'b0;
        @(posedge sclk);
        #1;
        rstn    = 1'b1;
        m_level = 0;
        m_lane  = 0;
        m_part  = '0;
        exp_q.delete();
        check("rst_empty", {31'd0, empty_o}, 32'd1);
        check("rst_full",  {31'd0, full_o},  32'd0);
        check("rst_rdata", rdata_o, 32'h0);
`ifdef FIFO8_32_LEVEL_EN
        check("rst_level", {27'd0, level_o}, 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rstn    = 1'b0;
        wr_i    = 1'b0;
        rd_i    = 1'b0;
        wdata_i = 8'h00;
        m_level = 0;
        m_lane  = 0;
        m_part  = '0;
        repeat (2) @(posedge sclk);
        #1;
        do_reset();

        // Packing
        cycle(1'b1, 8'h11, 1'b0);
        cycle(1'b1, 8'h22, 1'b0);
        cycle(1'b1, 8'h33, 1'b0);
        cycle(1'b1, 8'h44, 1'b0);
        check("pack_word", rdata_o, 32'h44332211);
        cycle(1'b0, 8'h00, 1'b1);
        check("pack_empty_after_rd", {31'd0, empty_o}, 32'd1);

        // Partial word: read is ignored until the 4th byte arrives
        cycle(1'b1, 8'hAA, 1'b0);
        cycle(1'b1, 8'hBB, 1'b0);
        cycle(1'b1, 8'hCC, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        check("partial_empty", {31'd0, empty_o}, 32'd1);
        cycle(1'b1, 8'hDD, 1'b0);
        check("partial_word", rdata_o, 32'hDDCCBBAA);
`ifdef FIFO8_32_LEVEL_EN
        check("partial_level", {27'd0, level_o}, 32'd4);
`endif
        cycle(1'b0, 8'h00, 1'b1);

        // Full, dropped write, drain
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0);
        check("full_set", {31'd0, full_o}, 32'd1);
        cycle(1'b1, 8'hFF, 1'b0);
        check("full_word0", rdata_o, 32'h03020100);
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1);
        check("full_drained", {31'd0, empty_o}, 32'd1);

        // Simultaneous read/write while full
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0);
        cycle(1'b1, 8'h5A, 1'b1);
        check("sim_not_full", {31'd0, full_o}, 32'd0);
        check("sim_word1", rdata_o, 32'h07060504);
`ifdef FIFO8_32_LEVEL_EN
        check("sim_level", {27'd0, level_o}, 32'd12);
`endif
        cycle(1'b1, 8'h5A, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1);
        check("sim_partial_left", {31'd0, empty_o}, 32'd1);

        // Stream across pointer wrap with interleaved reads
        do_reset();
        for (int i = 0; i < 40; i++) cycle(1'b1, 8'h80 + 8'(i), (i % 3) == 2);
        for (int i = 0; i < 12; i++) cycle(1'b0, 8'h00, 1'b1);
        check("wrap_drained", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a word
        cycle(1'b1, 8'hE1, 1'b0);
        cycle(1'b1, 8'hE2, 1'b0);
        do_reset();
        cycle(1'b1, 8'hA1, 1'b0);
        cycle(1'b1, 8'hA2, 1'b0);
        cycle(1'b1, 8'hA3, 1'b0);
        check("rst_mid_partial", {31'd0, empty_o}, 32'd1);
        cycle(1'b1, 8'hA4, 1'b0);
        check("rst_fresh_word", rdata_o, 32'hA4A3A2A1);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
